output_vote: RTL and testbench

- Downstream of the output-layer XNOR/popcount stage.
- That stage emits one NUM_CLASSES-bit binary decision vector per time step, across NUM_STEPS steps. This block consumes those vectors.
- Per class: counts the number of time steps whose bit is 1.
- After the last step: scans the counts sequentially, then reports the winning class index and its vote score.
- Final stage of the inference datapath.

---
 rtl/output_vote_if.sv | 35 +++
 rtl/output_vote.sv | 160 ++++++++++++++++
 tb/tb_output_vote.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/output_vote_if.sv
// Handshake bundle between the output-layer popcount stage and the vote block.
// OUTPUT_VOTE_MARGIN_EN adds the margin_out result field.
interface output_vote_if #(
    parameter int NUM_CLASSES = 8,
    parameter int CNT_W       = 6,
    parameter int IDX_W       = 3
);
    logic                   start;
    logic [NUM_CLASSES-1:0] data_in;
    logic                   data_in_valid;
    logic                   in_ready;
    logic [IDX_W-1:0]       class_out;
    logic [CNT_W-1:0]       score_out;
    logic                   result_valid;
    logic                   done;
`ifdef OUTPUT_VOTE_MARGIN_EN
    logic [CNT_W-1:0]       margin_out;
`endif

    modport master (
        output start, data_in, data_in_valid,
        input  in_ready, class_out, score_out, result_valid, done
`ifdef OUTPUT_VOTE_MARGIN_EN
        , input margin_out
`endif
    );

    modport slave (
        input  start, data_in, data_in_valid,
        output in_ready, class_out, score_out, result_valid, done
`ifdef OUTPUT_VOTE_MARGIN_EN
        , output margin_out
`endif
    );
endinterface

// File: rtl/output_vote.sv
// Per-class vote accumulator with sequential argmax scan (final inference stage).
// OUTPUT_VOTE_MARGIN_EN adds runner-up tracking and margin_out.
module output_vote #(
    parameter int NUM_CLASSES = 8,
    parameter int NUM_STEPS   = 32,
    parameter int CNT_W       = 6,
    parameter int IDX_W       = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    output_vote_if.slave    bus
);
    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_STEPS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CLASSES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
    logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [IDX_W-1:0] scan_q, scan_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [CNT_W-1:0] best_q, best_d;
    logic [IDX_W-1:0] class_q, class_d;
    logic [CNT_W-1:0] score_q, score_d;
    logic             rv_q, rv_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] cur;
    logic             hit;
    logic [CNT_W-1:0] nb_score;
    logic [IDX_W-1:0] nb_idx;

    assign cur      = cnt_q[scan_q];
    assign hit      = cur > best_q;
    assign nb_score = hit ? cur : best_q;
    assign nb_idx   = hit ? scan_q : best_idx_q;

`ifdef OUTPUT_VOTE_MARGIN_EN
    logic [CNT_W-1:0] sec_q, sec_d;
    logic [CNT_W-1:0] margin_q, margin_d;
    logic [CNT_W-1:0] nsec;

    // A new best pushes the previous best down to runner-up.
    assign nsec = hit ? best_q : ((cur > sec_q) ? cur : sec_q);
    assign bus.margin_out = margin_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        scan_d     = scan_q;
        best_idx_d = best_idx_q;
        best_d     = best_q;
        class_d    = class_q;
        score_d    = score_q;
        rv_d       = 1'b0;
        done_d     = done_q;
`ifdef OUTPUT_VOTE_MARGIN_EN
        sec_d      = sec_q;
        margin_d   = margin_q;
`endif
        if (bus.start) begin
            for (int k = 0; k < NUM_CLASSES; k++) cnt_d[k] = '0;
            beat_d     = '0;
            scan_d     = '0;
            best_idx_d = '0;
            best_d     = '0;
            done_d     = 1'b0;
            state_d    = ACCUM;
`ifdef OUTPUT_VOTE_MARGIN_EN
            sec_d      = '0;
`endif
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.data_in_valid) begin
                        for (int k = 0; k < NUM_CLASSES; k++)
                            cnt_d[k] = cnt_q[k] + CNT_W'(bus.data_in[k]);
                        beat_d = beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            state_d    = SCAN;
                            scan_d     = '0;
                            best_idx_d = '0;
                            best_d     = '0;
`ifdef OUTPUT_VOTE_MARGIN_EN
                            sec_d      = '0;
`endif
                        end
                    end
                end
                SCAN: begin
                    best_idx_d = nb_idx;
                    best_d     = nb_score;
`ifdef OUTPUT_VOTE_MARGIN_EN
                    sec_d      = nsec;
`endif
                    if (scan_q == LAST_IDX) begin
                        class_d = nb_idx;
                        score_d = nb_score;
                        rv_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
`ifdef OUTPUT_VOTE_MARGIN_EN
                        margin_d = nb_score - nsec;
`endif
                    end else begin
                        scan_d = scan_q + 1'b1;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            for (int k = 0; k < NUM_CLASSES; k++) cnt_q[k] <= '0;
            beat_q     <= '0;
            scan_q     <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
            class_q    <= '0;
            score_q    <= '0;
            rv_q       <= 1'b0;
            done_q     <= 1'b0;
`ifdef OUTPUT_VOTE_MARGIN_EN
            sec_q      <= '0;
            margin_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            scan_q     <= scan_d;
            best_idx_q <= best_idx_d;
            best_q     <= best_d;
            class_q    <= class_d;
            score_q    <= score_d;
            rv_q       <= rv_d;
            done_q     <= done_d;
`ifdef OUTPUT_VOTE_MARGIN_EN
            sec_q      <= sec_d;
            margin_q   <= margin_d;
`endif
        end
    end

    assign bus.in_ready     = (state_q == ACCUM);
    assign bus.class_out    = class_q;
    assign bus.score_out    = score_q;
    assign bus.result_valid = rv_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_output_vote.sv
// Randomised scoreboard bench for output_vote.
// Define OUTPUT_VOTE_MARGIN_EN to also check margin_out.
module tb_output_vote;
    localparam int NC = 8;
    localparam int NS = 32;
    localparam int CW = 6;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_vote_if #(.NUM_CLASSES(NC), .CNT_W(CW), .IDX_W(IW)) bus ();

    output_vote #(
        .NUM_CLASSES(NC), .NUM_STEPS(NS), .CNT_W(CW), .IDX_W(IW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int cls;
        int score;
        int margin;
        int due;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    int votes[NC];
    int nbeats;
    bit accum;
    bit mdone;
    int last_cls, last_score, last_margin;
    int pend_cls, pend_score, pend_margin;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.result_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result class=%0d t=%0t", bus.class_out, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("class_out", bus.class_out, e.cls);
                chk("score_out", bus.score_out, e.score);
`ifdef OUTPUT_VOTE_MARGIN_EN
                chk("margin_out", bus.margin_out, e.margin);
`endif
                chk("latency", cyc, e.due);
                chk("done_at_result", bus.done, 1);
            end
        end
    end

    task automatic model_clear();
        for (int k = 0; k < NC; k++) votes[k] = 0;
        nbeats = 0;
        accum = 1'b1;
        mdone = 1'b0;
    endtask

    // Winner = lowest index holding the maximum; runner-up = max of the rest.
    task automatic model_result();
        int best, idx, second;
        best = -1;
        idx = 0;
        for (int k = 0; k < NC; k++)
            if (votes[k] > best) begin best = votes[k]; idx = k; end
        second = 0;
        for (int k = 0; k < NC; k++)
            if (k != idx && votes[k] > second) second = votes[k];
        pend_cls = idx;
        pend_score = best;
        pend_margin = best - second;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [NC-1:0] d);
        bus.data_in = d;
        bus.data_in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.data_in_valid = 1'b0;
        bus.data_in = '0;
        if (accum) begin
            for (int k = 0; k < NC; k++) votes[k] += int'(d[k]);
            nbeats++;
            if (nbeats == NS) begin
                accum = 1'b0;
                model_result();
                q.push_back('{pend_cls, pend_score, pend_margin, cyc + 8});
            end
        end
    endtask

    task automatic beat_g(input logic [NC-1:0] d);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        beat(d);
    endtask

    task automatic do_start(input bit with_beat, input logic [NC-1:0] d);
        bus.start = 1'b1;
        bus.data_in_valid = with_beat;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.data_in_valid = 1'b0;
        bus.data_in = '0;
        q.delete();
        model_clear();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) idle(1);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL result_timeout pending=%0d required=0", q.size());
            q.delete();
        end else begin
            last_cls = pend_cls;
            last_score = pend_score;
            last_margin = pend_margin;
            mdone = 1'b1;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_class"}, bus.class_out, last_cls);
        chk({tag, "_score"}, bus.score_out, last_score);
`ifdef OUTPUT_VOTE_MARGIN_EN
        chk({tag, "_margin"}, bus.margin_out, last_margin);
`endif
        chk({tag, "_done"}, bus.done, mdone);
        chk({tag, "_in_ready"}, bus.in_ready, accum);
        chk({tag, "_rv"}, bus.result_valid, 0);
    endtask

    task automatic run_const(input logic [NC-1:0] d, input bit gaps);
        for (int i = 0; i < NS; i++)
            if (gaps) beat_g(d);
            else beat(d);
        drain();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.data_in = '0;
        bus.data_in_valid = 1'b0;
        model_clear();
        last_cls = 0; last_score = 0; last_margin = 0;
        pend_cls = 0; pend_score = 0; pend_margin = 0;

        #12;
        check_state("reset");
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_reset");

        run_const(8'b0010_0000, 1'b0);
        check_state("class5");

        for (int i = 0; i < 10; i++) beat(8'hFF);
        check_state("done_hold");

        do_start(1'b0, '0);
        run_const(8'b1000_0100, 1'b1);
        check_state("tie");

        begin
            logic [NC-1:0] mix[$];
            int j;
            logic [NC-1:0] t;
            do_start(1'b0, '0);
            for (int i = 0; i < 20; i++) mix.push_back(8'h02);
            for (int i = 0; i < 12; i++) mix.push_back(8'h08);
            for (int i = NS - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = mix[i]; mix[i] = mix[j]; mix[j] = t;
            end
            for (int i = 0; i < NS; i++) beat_g(mix[i]);
            drain();
            check_state("mixed");
        end

        do_start(1'b0, '0);
        run_const(8'h80, 1'b1);
        check_state("class7");

        do_start(1'b0, '0);
        for (int i = 0; i < 15; i++) beat(8'h10);
        #2 rst_n = 1'b0;
        model_clear();
        last_cls = 0; last_score = 0; last_margin = 0;
        #1;
        check_state("async_reset");
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_const(8'h01, 1'b0);
        check_state("after_reset");

        do_start(1'b0, '0);
        for (int i = 0; i < NS; i++) beat($urandom_range(1, 255));
        idle(3);
        do_start(1'b0, '0);
        idle(12);
        check_state("abort_scan");

        run_const(8'h00, 1'b1);
        check_state("all_zero");

        for (int r = 0; r < 5; r++) begin
            do_start(r[0], $urandom_range(0, 255));
            for (int i = 0; i < NS; i++)
                beat_g($urandom_range(0, 255) & $urandom_range(0, 255));
            drain();
            check_state("random");
            for (int i = 0; i < 3; i++) beat_g($urandom_range(0, 255));
            check_state("random_hold");
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
